// File: rtl/pwm_audio_decoder.sv
// Receive-side decoder for the 1-bit APU sound line.
// Recovers the per-window high count (level) and the rising-edge period (pitch).
module pwm_audio_decoder #(
    parameter int WINDOW_LOG2 = 8,
    parameter int PERIOD_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sound_in,
    output logic [WINDOW_LOG2:0]   duty_out,
    output logic                   duty_valid,
    output logic [PERIOD_BITS-1:0] period_out,
    output logic                   period_valid,
    output logic                   period_overflow,
    output logic                   silent
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_MEASURE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   w_s;
    logic                   w_rise;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync[0] <= sound_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
            r_s_d <= w_s;
        end
    end

    // Window path: the last cycle's sample is folded into duty directly so the
    // accumulator never has to hold the full-scale value.
    logic [WINDOW_LOG2-1:0] r_win_cnt;
    logic [WINDOW_LOG2-1:0] r_high_acc;
    logic                   r_edge_seen;
    logic [WINDOW_LOG2:0]   r_duty;
    logic                   r_duty_valid;
    logic                   r_silent;
    logic                   w_win_last;

    assign w_win_last = &r_win_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_cnt    <= '0;
            r_high_acc   <= '0;
            r_edge_seen  <= 1'b0;
            r_duty       <= '0;
            r_duty_valid <= 1'b0;
            r_silent     <= 1'b1;
        end else begin
            r_win_cnt    <= r_win_cnt + 1'b1;
            r_duty_valid <= 1'b0;
            if (w_win_last) begin
                r_duty       <= {1'b0, r_high_acc} + (WINDOW_LOG2+1)'(w_s);
                r_silent     <= ~(r_edge_seen | w_rise);
                r_duty_valid <= 1'b1;
                r_high_acc   <= '0;
                r_edge_seen  <= 1'b0;
            end else begin
                r_high_acc  <= r_high_acc + WINDOW_LOG2'(w_s);
                r_edge_seen <= r_edge_seen | w_rise;
            end
        end
    end

    // Period path: after an overflow the next rise only re-arms the counter.
    logic                   r_state;
    logic [PERIOD_BITS-1:0] r_per_cnt;
    logic [PERIOD_BITS-1:0] r_period;
    logic                   r_period_valid;
    logic                   r_period_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_per_cnt      <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_period_ovf   <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            r_period_ovf   <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_rise) begin
                    r_per_cnt <= PERIOD_BITS'(1);
                    r_state   <= ST_MEASURE;
                end
            end else begin
                if (w_rise) begin
                    r_period       <= r_per_cnt;
                    r_period_valid <= 1'b1;
                    r_per_cnt      <= PERIOD_BITS'(1);
                end else if (&r_per_cnt) begin
                    r_period_ovf <= 1'b1;
                    r_per_cnt    <= '0;
                    r_state      <= ST_IDLE;
                end else begin
                    r_per_cnt <= r_per_cnt + 1'b1;
                end
            end
        end
    end

    assign duty_out        = r_duty;
    assign duty_valid      = r_duty_valid;
    assign silent          = r_silent;
    assign period_out      = r_period;
    assign period_valid    = r_period_valid;
    assign period_overflow = r_period_ovf;

endmodule

// File: tb/tb_pwm_audio_decoder.sv
// Directed bench for pwm_audio_decoder: level, square, PWM, overflow and reset-recovery cases.
module tb_pwm_audio_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sound_in = 1'b0;
    logic [8:0] duty_out;
    logic       duty_valid;
    logic [15:0] period_out;
    logic       period_valid;
    logic       period_overflow;
    logic       silent;

    int checks = 0;
    int failures = 0;

    int cyc, wi;
    int dv_cnt, first_dv_cyc, last_dv_cyc, first_duty, first_sil, dmin, dmax, nsil;
    int pv_cnt, first_pv_cyc, first_per, pmin, pmax;
    int po_cnt, po_cyc;

    pwm_audio_decoder #(.WINDOW_LOG2(8), .PERIOD_BITS(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sound_in(sound_in),
        .duty_out(duty_out), .duty_valid(duty_valid),
        .period_out(period_out), .period_valid(period_valid),
        .period_overflow(period_overflow), .silent(silent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        cyc = 0;
        dv_cnt = 0; first_dv_cyc = -1; last_dv_cyc = -1; first_duty = -1; first_sil = -1;
        dmin = 99999; dmax = -1; nsil = 0;
        pv_cnt = 0; first_pv_cyc = -1; first_per = -1; pmin = 99999; pmax = -1;
        po_cnt = 0; po_cyc = -1;
    endtask

    // Drive one cycle, then sample just after the edge; cyc is the cycle now observed.
    task automatic tick(input logic v);
        sound_in = v;
        @(posedge clk);
        #1;
        cyc++;
        if (duty_valid) begin
            if (dv_cnt == 0) begin
                first_dv_cyc = cyc; first_duty = int'(duty_out); first_sil = int'(silent);
            end else begin
                if (int'(duty_out) < dmin) dmin = int'(duty_out);
                if (int'(duty_out) > dmax) dmax = int'(duty_out);
                if (silent) nsil++;
            end
            last_dv_cyc = cyc;
            dv_cnt++;
        end
        if (period_valid) begin
            if (pv_cnt == 0) begin
                first_pv_cyc = cyc; first_per = int'(period_out);
            end
            if (int'(period_out) < pmin) pmin = int'(period_out);
            if (int'(period_out) > pmax) pmax = int'(period_out);
            pv_cnt++;
        end
        if (period_overflow) begin
            po_cnt++; po_cyc = cyc;
        end
    endtask

    // per/hi give a wave that is high for the first hi samples of every per samples.
    task automatic wave(input int n, input int per, input int hi);
        for (int i = 0; i < n; i++) begin
            tick((wi % per) < hi);
            wi++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (4) tick(1'b0);
        reset = 1'b0;
        clr_stats();
        wi = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_duty_out",   int'(duty_out), 0);
        chk("rst_duty_valid", int'(duty_valid), 0);
        chk("rst_period_out", int'(period_out), 0);
        chk("rst_period_vld", int'(period_valid), 0);
        chk("rst_period_ovf", int'(period_overflow), 0);
        chk("rst_silent",     int'(silent), 1);

        // Line held low for four windows
        wave(1024, 1, 0);
        chk("low_dv_cnt",    dv_cnt, 4);
        chk("low_first_dv",  first_dv_cyc, 256);
        chk("low_last_dv",   last_dv_cyc, 1024);
        chk("low_first_duty", first_duty, 0);
        chk("low_first_sil", first_sil, 1);
        chk("low_dmax",      dmax, 0);
        chk("low_nsil",      nsil, 3);
        chk("low_pv_cnt",    pv_cnt, 0);
        chk("low_po_cnt",    po_cnt, 0);

        // Line held high from release: first window loses the sync latency
        do_reset();
        wave(768, 1, 1);
        chk("high_dv_cnt",     dv_cnt, 3);
        chk("high_first_duty", first_duty, 254);
        chk("high_first_sil",  first_sil, 0);
        chk("high_dmin",       dmin, 256);
        chk("high_dmax",       dmax, 256);
        chk("high_nsil",       nsil, 2);
        chk("high_pv_cnt",     pv_cnt, 0);
        chk("high_po_cnt",     po_cnt, 0);

        // 50% square, period 128: rises on s at 2,130,258,...
        do_reset();
        wave(768, 128, 64);
        chk("sq_dv_cnt",     dv_cnt, 3);
        chk("sq_first_duty", first_duty, 128);
        chk("sq_first_sil",  first_sil, 0);
        chk("sq_dmin",       dmin, 128);
        chk("sq_dmax",       dmax, 128);
        chk("sq_nsil",       nsil, 0);
        chk("sq_pv_cnt",     pv_cnt, 5);
        chk("sq_first_pv",   first_pv_cyc, 131);
        chk("sq_pmin",       pmin, 128);
        chk("sq_pmax",       pmax, 128);
        chk("sq_po_cnt",     po_cnt, 0);

        // PWM period 16, 4 high
        do_reset();
        wave(768, 16, 4);
        chk("pwm_dv_cnt",     dv_cnt, 3);
        chk("pwm_first_duty", first_duty, 64);
        chk("pwm_dmin",       dmin, 64);
        chk("pwm_dmax",       dmax, 64);
        chk("pwm_nsil",       nsil, 0);
        chk("pwm_pv_cnt",     pv_cnt, 47);
        chk("pwm_first_pv",   first_pv_cyc, 19);
        chk("pwm_pmin",       pmin, 16);
        chk("pwm_pmax",       pmax, 16);

        // One rise then held high: sound_in rises in cycle 10, s rise in cycle 12,
        // overflow registered 65535 cycles later, visible in cycle 12+65536
        do_reset();
        wave(10, 1, 0);
        wave(70000, 1, 1);
        chk("ovf_po_cnt", po_cnt, 1);
        chk("ovf_po_cyc", po_cyc, 65548);
        chk("ovf_pv_cnt", pv_cnt, 0);
        clr_stats();
        wave(10, 1, 0);
        wave(290, 1, 1);
        wave(10, 1, 0);
        wave(20, 1, 1);
        chk("rearm_pv_cnt", pv_cnt, 1);
        chk("rearm_period", first_per, 300);
        chk("rearm_po_cnt", po_cnt, 0);

        // Reset for 3 cycles at win_cnt=100 while a period-128 square runs
        do_reset();
        wave(100, 128, 64);
        reset = 1'b1;
        wave(3, 128, 64);
        reset = 1'b0;
        clr_stats();
        wave(300, 128, 64);
        chk("mid_dv_cnt",     dv_cnt, 1);
        chk("mid_first_dv",   first_dv_cyc, 256);
        chk("mid_first_duty", first_duty, 128);
        chk("mid_first_sil",  first_sil, 0);
        chk("mid_pv_cnt",     pv_cnt, 2);
        chk("mid_first_pv",   first_pv_cyc, 156);
        chk("mid_first_per",  first_per, 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_audio_decoder.md
Name: pwm_audio_decoder

Overview:
- Receive side of the 1-bit PWM/square `sound` line driven by the audio processing unit.
- Recovers two quantities from the line:
  - Duty/level: high-time count per fixed window (PCM-like sample).
  - Tone period: cycles between rising edges.
- Used by in-system test logic, VU/indicator logic and the verification bench to check which collision sound is playing and at what pitch.

Parameters:
- WINDOW_LOG2, 8, window length = 2^WINDOW_LOG2 clk cycles.
- PERIOD_BITS, 16, width of the period counter/output.
- SYNC_STAGES, 2, synchronizer flops on sound_in (minimum 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sound_in  input  1  PWM/square audio line.
- duty_out  output  WINDOW_LOG2+1  high samples in last completed window, range 0..2^WINDOW_LOG2.
- duty_valid  output  1  one-cycle pulse when duty_out updates.
- period_out  output  PERIOD_BITS  cycles between last two rising edges.
- period_valid  output  1  one-cycle pulse when period_out updates.
- period_overflow  output  1  one-cycle pulse when no rising edge occurs within 2^PERIOD_BITS-1 cycles of the previous one.
- silent  output  1  high when the last completed window contained no rising edge.

Behaviour:
- Reset is synchronous, active-high on clk. Reset values:
  - Synchronizer flops 0, s_d 0.
  - win_cnt 0, high_acc 0, edge_seen 0.
  - per_cnt 0, state IDLE.
  - duty_out 0, duty_valid 0, period_out 0, period_valid 0, period_overflow 0, silent 1.
- Synchronizer: sound_in passes SYNC_STAGES flops to give s; s_d = s delayed 1 cycle. rise = s & ~s_d. A sound_in change appears on s SYNC_STAGES cycles later.
- Window path:
  - win_cnt (WINDOW_LOG2 bits) increments every cycle and wraps from all-ones to 0.
  - When win_cnt != all-ones: high_acc += s; edge_seen |= rise.
  - When win_cnt == all-ones (last cycle of window):
    - duty_out <= high_acc + s. The window is exactly 2^WINDOW_LOG2 samples of s; width WINDOW_LOG2+1 so the all-high window reads 2^WINDOW_LOG2, no wrap.
    - silent <= ~(edge_seen | rise).
    - duty_valid <= 1 for the next cycle only.
    - high_acc <= 0, edge_seen <= 0.
  - First duty_valid is asserted on cycle 2^WINDOW_LOG2 after reset deasserts (cycle 0 = first non-reset cycle).
- Period FSM, states IDLE and MEASURE:
  - IDLE: on rise, per_cnt <= 1 and go to MEASURE. No period_valid.
  - MEASURE, rise: period_out <= per_cnt, period_valid pulses 1 cycle, per_cnt <= 1. Rising edges at cycles t and t+N give period_out = N.
  - MEASURE, no rise, per_cnt < all-ones: per_cnt += 1.
  - MEASURE, no rise, per_cnt == all-ones: period_overflow pulses 1 cycle, per_cnt <= 0, go to IDLE. The next rise only re-arms; it does not produce a measurement.
  - Rise in the same cycle per_cnt == all-ones is a valid measurement: period_out = 2^PERIOD_BITS-1, no overflow.
- Simultaneous events: duty_valid and period_valid may assert in the same cycle. The two paths are independent.
- Reset mid-window or mid-measurement: partial accumulations are discarded. No valid pulses until a full new window or edge pair completes.
- Output registers hold their values between valid pulses.
- All outputs are registered. No combinational path from sound_in to any output.

Test Plan:
- sound_in held 0 after reset for 1024 cycles -> duty_valid at cycles 256, 512, 768, 1024 with duty_out=0, silent=1, no period_valid or period_overflow.
- sound_in held 1 from reset release -> every window after the first has duty_out=256 (9'h100), silent=1, no period_valid. The first window reads 256-SYNC_STAGES=254.
- Square toggling every 64 cycles (50%, period 128) -> period_valid every 128 cycles with period_out=128. Every duty window reads duty_out=128, silent=0.
- PWM period 16, 4 high/12 low -> period_out=16 on every rise after the first; duty_out=64 each window; silent=0.
- One rising edge, then sound_in held high for 70000 cycles -> period_overflow pulses exactly 65535 cycles after the rise is seen on s. The next two rises 300 cycles apart give one period_valid with period_out=300.
- Square period 128 running; reset asserted for 3 cycles at win_cnt=100 -> no duty_valid until 256 cycles after reset release. First period_valid comes only at the second rise after release, and is correct (128).
